// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/ram_arb_if_if.sv
// One requester port of the RAM arbiter: request/grant handshake plus response.
interface ram_port_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_arb_rr.sv
// Two-way round-robin arbiter; holds the last-granted pointer.
module ram_arb_rr
  import ram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  port_e last_q, last_d;

  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    if (rstn_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == PORT1) ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
    if (gnt_o[0]) begin
      last_d = PORT0;
    end else if (gnt_o[1]) begin
      last_d = PORT1;
    end
  end

  // Pointer starts at port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      last_q <= PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arb_if.sv
// Two-port arbiter in front of a single-port 32-bit RAM with one-cycle read latency.
module ram_arb_if
  import ram_arb_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  ram_port_if.slave             p0,
  ram_port_if.slave             p1,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [31:0]           ram_wdata_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  input  logic [31:0]           ram_rdata_i
);

  logic [NUM_PORTS-1:0] gnt;
  logic                 any_gnt;
  logic                 in_range;
  req_t                 req0, req1, req_sel;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic                 rd_q, rd_d;
  logic                 err_q, err_d;
  logic [NUM_PORTS-1:0] rvalid;
  rsp_t                 rsp;
  logic                 unused_addr_lsb;

  ram_arb_rr u_rr (
    .clk    (clk),
    .rstn_i (rstn_i),
    .req_i  ({p1.req, p0.req}),
    .gnt_o  (gnt)
  );

  assign req0 = '{addr: p0.addr, we: p0.we, be: p0.be, wdata: p0.wdata};
  assign req1 = '{addr: p1.addr, we: p1.we, be: p1.be, wdata: p1.wdata};
  assign unused_addr_lsb = ^req_sel.addr[1:0];

  always_comb begin
    any_gnt     = |gnt;
    req_sel     = gnt[1] ? req1 : req0;
    in_range    = (req_sel.addr[31:ADDR_WIDTH+2] == '0);
    ram_en_o    = any_gnt & in_range;
    ram_we_o    = ram_en_o & req_sel.we;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_be_o    = '0;
    if (any_gnt) begin
      ram_addr_o  = req_sel.addr[ADDR_WIDTH+1:2];
      ram_wdata_o = req_sel.wdata;
      ram_be_o    = req_sel.be;
    end
    rvalid_d = gnt;
    rd_d     = ram_en_o & ~req_sel.we;
    err_d    = any_gnt & ~in_range;
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      rvalid_q <= '0;
      rd_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  // Gating with rstn_i drops a response whose grant was followed by reset.
  assign rvalid    = rvalid_q & {NUM_PORTS{rstn_i}};
  assign rsp.rdata = rd_q ? ram_rdata_i : '0;
  assign rsp.err   = err_q;

  assign p0.gnt    = gnt[0];
  assign p1.gnt    = gnt[1];
  assign p0.rvalid = rvalid[0];
  assign p1.rvalid = rvalid[1];
  assign p0.rdata  = rvalid[0] ? rsp.rdata : '0;
  assign p1.rdata  = rvalid[1] ? rsp.rdata : '0;
  assign p0.err    = rvalid[0] & rsp.err;
  assign p1.err    = rvalid[1] & rsp.err;

endmodule

// File: tb/tb_ram_arb_if.sv
// Directed bench for ram_arb_if with a behavioural byte-enabled RAM model.
module tb_ram_arb_if;

  localparam int RAM_SIZE   = 32768;
  localparam int ADDR_WIDTH = $clog2(RAM_SIZE);

  logic                  clk = 1'b0;
  logic                  rstn_i;
  logic                  ram_en_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic                  ram_we_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_rdata_i;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [RAM_SIZE];

  ram_port_if p0_if ();
  ram_port_if p1_if ();

  ram_arb_if #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk         (clk),
    .rstn_i      (rstn_i),
    .p0          (p0_if.slave),
    .p1          (p1_if.slave),
    .ram_en_o    (ram_en_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int port, input logic req, input logic we,
                     input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    if (port == 0) begin
      p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.be = be; p0_if.wdata = wdata;
    end else begin
      p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.be = be; p1_if.wdata = wdata;
    end
  endtask

  task automatic idle(input int port);
    drv(port, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  initial begin
    ram_rdata_i = '0;
    rstn_i = 1'b0;
    idle(0);
    idle(1);
    drv(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);

    // reset: request present but nothing granted
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_gnt0",   32'(p0_if.gnt), 32'd0);
    chk("rst_en",     32'(ram_en_o), 32'd0);
    chk("rst_rvalid", 32'(p0_if.rvalid), 32'd0);

    @(negedge clk);
    rstn_i = 1'b1;
    idle(0); #1;
    chk("idle_en",    32'(ram_en_o), 32'd0);
    chk("idle_addr",  32'(ram_addr_o), 32'd0);
    chk("idle_wdata", ram_wdata_o, 32'd0);
    chk("idle_be",    32'(ram_be_o), 32'd0);

    // p0 write 0x100, idle, read 0x100
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF); #1;
    chk("w_gnt0",  32'(p0_if.gnt), 32'd1);
    chk("w_gnt1",  32'(p1_if.gnt), 32'd0);
    chk("w_en",    32'(ram_en_o), 32'd1);
    chk("w_we",    32'(ram_we_o), 32'd1);
    chk("w_addr",  32'(ram_addr_o), 32'h40);
    chk("w_wdata", ram_wdata_o, 32'hDEADBEEF);
    @(negedge clk);
    idle(0); #1;
    chk("w_rvalid", 32'(p0_if.rvalid), 32'd1);
    chk("w_rdata",  p0_if.rdata, 32'd0);
    chk("w_err",    32'(p0_if.err), 32'd0);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("r_gnt0",   32'(p0_if.gnt), 32'd1);
    chk("r_we",     32'(ram_we_o), 32'd0);
    chk("r_addr",   32'(ram_addr_o), 32'h40);
    chk("r_gap",    32'(p0_if.rvalid), 32'd0);
    @(negedge clk);
    idle(0); #1;
    chk("r_rvalid", 32'(p0_if.rvalid), 32'd1);
    chk("r_rdata",  p0_if.rdata, 32'hDEADBEEF);
    chk("r_err",    32'(p0_if.err), 32'd0);
    @(negedge clk); #1;
    chk("r_once",   32'(p0_if.rvalid), 32'd0);
    chk("r_zero",   p0_if.rdata, 32'd0);

    // p1 back-to-back: full write, byte-lane write, read
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 32'h200, 4'hF, 32'h11223344); #1;
    chk("b_gnt1", 32'(p1_if.gnt), 32'd1);
    chk("b_addr", 32'(ram_addr_o), 32'h80);
    @(negedge clk);
    drv(1, 1'b1, 1'b1, 32'h200, 4'h2, 32'h0000AB00); #1;
    chk("b_be",      32'(ram_be_o), 32'h2);
    chk("b_rvalid1", 32'(p1_if.rvalid), 32'd1);
    chk("b_gnt2",    32'(p1_if.gnt), 32'd1);
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0); #1;
    chk("b_rvalid2", 32'(p1_if.rvalid), 32'd1);
    chk("b_gnt3",    32'(p1_if.gnt), 32'd1);
    @(negedge clk);
    idle(1); #1;
    chk("b_rvalid3", 32'(p1_if.rvalid), 32'd1);
    chk("b_merge",   p1_if.rdata, 32'h1122AB44);

    // out-of-range read and write; RAM must stay intact
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 32'(4 * RAM_SIZE), 4'hF, 32'h0); #1;
    chk("oor_gnt", 32'(p0_if.gnt), 32'd1);
    chk("oor_en",  32'(ram_en_o), 32'd0);
    @(negedge clk);
    drv(0, 1'b1, 1'b1, 32'(4 * RAM_SIZE + 32'h100), 4'hF, 32'h0); #1;
    chk("oor_rvalid", 32'(p0_if.rvalid), 32'd1);
    chk("oor_err",    32'(p0_if.err), 32'd1);
    chk("oor_rdata",  p0_if.rdata, 32'd0);
    chk("oorw_en",    32'(ram_en_o), 32'd0);
    chk("oorw_we",    32'(ram_we_o), 32'd0);
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("oorw_err", 32'(p0_if.err), 32'd1);
    @(negedge clk);
    idle(0); #1;
    chk("intact_rdata", p0_if.rdata, 32'hDEADBEEF);
    chk("intact_err",   32'(p0_if.err), 32'd0);

    // p1 then p0 grant; reset right after the p0 grant drops its response
    @(negedge clk);
    drv(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0); #1;
    chk("pre_gnt1", 32'(p1_if.gnt), 32'd1);
    @(negedge clk);
    idle(1);
    drv(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #1;
    chk("pre_gnt0", 32'(p0_if.gnt), 32'd1);
    @(negedge clk);
    rstn_i = 1'b0;
    idle(0); #1;
    chk("rst_drop_rvalid", 32'(p0_if.rvalid), 32'd0);
    chk("rst_drop_rdata",  p0_if.rdata, 32'd0);

    // release reset, both ports read continuously for 4 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rstn_i = 1'b1;
      if (i < 4) begin
        drv(0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        drv(1, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0);
      end else begin
        idle(0);
        idle(1);
      end
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 32'(p0_if.gnt), 32'((i < 4) && (i % 2 == 0)));
      chk($sformatf("rr_gnt1_%0d", i), 32'(p1_if.gnt), 32'((i < 4) && (i % 2 == 1)));
      chk($sformatf("rr_rv0_%0d", i), 32'(p0_if.rvalid), 32'((i == 1) || (i == 3)));
      chk($sformatf("rr_rv1_%0d", i), 32'(p1_if.rvalid), 32'((i == 2) || (i == 4)));
      chk($sformatf("rr_rd0_%0d", i), p0_if.rdata,
          ((i == 1) || (i == 3)) ? 32'hDEADBEEF : 32'h0);
      chk($sformatf("rr_rd1_%0d", i), p1_if.rdata,
          ((i == 2) || (i == 4)) ? 32'h1122AB44 : 32'h0);
    end

    @(negedge clk); #1;
    chk("end_en", 32'(ram_en_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
